barker_sync: RTL and testbench
==============================

// Module: barker_sync
// PURPOSE
//   Receive-side frame synchroniser for the BPSK link. Slides a 7-bit window over
//   the demodulated hard-decision bitstream, correlates it against the Barker code,
//   declares sync when the correlation reaches a threshold, then passes FRAME_LEN
//   payload bits downstream before returning to search. Counterpart of the Barker
//   generator on the transmit side; sits between the BPSK demodulator and the decoder.
// PARAMETERS
//   BARKER_CODE  7'b1110010  sync word; bit 6 is transmitted first
//   THRESH       7           min correlation to declare sync; legal range 1..7
//   FRAME_LEN    32          payload bits per frame after sync; >= 2
// PORTS
//   clk_sig      in   1  system clock
//   rst          in   1  asynchronous reset, active-high
//   en_p         in   1  bit strobe; bit_in is valid on cycles where en_p=1
//   bit_in       in   1  demodulated bit
//   corr         out  4  signed correlation of the current window, -7..+7
//   sync_p       out  1  one-cycle pulse on sync detection
//   locked       out  1  high while payload bits are being passed
//   data_out     out  1  payload bit (polarity-corrected)
//   data_valid   out  1  one-cycle qualifier for data_out
//   frame_end_p  out  1  one-cycle pulse with the last payload bit
//   polarity     out  1  1 = inverted Barker detected (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, immediate): window=0, fill=0, cnt=0, state=SEARCH; all outputs 0.
//   - Nothing advances on cycles with en_p=0. All outputs hold, except the pulses
//     (sync_p, data_valid, frame_end_p), which return to 0.
//   - On each en_p edge:
//       win_nxt = {win[5:0], bit_in}
//       m       = count of bits where win_nxt == BARKER_CODE
//       corr   <= 2*m - 7 (signed, 4 bits)
//     The window shifts in both states. fill increments, saturating at 7.
//   - FSM, 2 states:
//     SEARCH: if fill_nxt == 7 and corr_nxt >= THRESH: sync_p<=1, locked<=1,
//       cnt<=0, go to LOCKED. The sync pulse is high for exactly the cycle after
//       the en_p edge that carried the 7th code bit. No data_valid in SEARCH.
//     LOCKED: each en_p: data_out <= bit_in ^ pol_r, data_valid<=1, cnt++.
//       The correlator is not evaluated for sync.
//       When cnt == FRAME_LEN-1: frame_end_p<=1 alongside data_valid, locked<=0,
//       fill<=0, go to SEARCH. The next sync needs 7 fresh bits, so no
//       back-to-back trigger on payload tail.
//   - Latency: payload bit to data_out/data_valid is 1 cycle after its en_p edge.
//   - cnt width = $clog2(FRAME_LEN). cnt never exceeds FRAME_LEN-1.
//   - Reset mid-frame aborts the frame. No frame_end_p is emitted.
// CONFIGURATION
//   BARKER_POLARITY_EN defined: SEARCH also syncs when fill==7 and corr <= -THRESH
//     (180-degree BPSK phase ambiguity).
//     - Inverted match: pol_r<=1, polarity<=1.
//     - Normal match: pol_r<=0, polarity<=0.
//     - pol_r holds through the frame and inverts data_out.
//     - When both conditions could hold, only positive is possible since THRESH >= 1.
//   Undefined: only positive correlation syncs; pol_r and polarity are tied to 0.
// TESTING
//   1. Reset, send 1,1,1,0,0,1,0 -> corr=+7, sync_p high 1 cycle after 7th en_p,
//      locked=1.
//   2. Sync, then 32 bits of 0xA5A50F0F MSB-first -> 32 data_valid pulses, data_out
//      matches, frame_end_p with bit 32, locked=0 the cycle after.
//   3. THRESH=5, send 1111010 -> corr=+5, sync. THRESH=7, same bits -> corr=+5,
//      no sync.
//   4. Send 0001101 -> with BARKER_POLARITY_EN: corr=-7, sync, polarity=1, payload
//      0xA5A50F0F out as 0x5A5AF0F0. Without the macro: corr=-7, no sync.
//   5. rst pulse at payload bit 10 -> outputs 0 same cycle, state SEARCH. A code
//      sent after 6 bits only does not sync; it syncs after 7.
//   6. Random en_p gaps (0-5 idle cycles) over test 2 -> identical data/pulse
//      sequence; frame tail containing 1110010 immediately after frame_end_p
//      needs full refill.

Source files
------------

// File: rtl/barker_sync_if.sv
// Bit-strobe input / correlation, sync and payload output bundle for barker_sync.
// slave = synchroniser side, master = demodulator/decoder side.
interface barker_sync_if;
  logic       en_p;
  logic       bit_in;
  logic [3:0] corr;
  logic       sync_p;
  logic       locked;
  logic       data_out;
  logic       data_valid;
  logic       frame_end_p;
  logic       polarity;

  modport slave (
    input  en_p, bit_in,
    output corr, sync_p, locked, data_out, data_valid, frame_end_p, polarity
  );

  modport master (
    output en_p, bit_in,
    input  corr, sync_p, locked, data_out, data_valid, frame_end_p, polarity
  );
endinterface

// File: rtl/barker_sync.sv
// Barker-7 frame synchroniser: payload out 1 cycle after its en_p edge; no backpressure (strobe driven).
// BARKER_POLARITY_EN: also lock on the inverted code and un-invert the payload.
module barker_sync #(
  parameter logic [6:0] BARKER_CODE = 7'b1110010,
  parameter int         THRESH      = 7,
  parameter int         FRAME_LEN   = 32
) (
  input  logic          clk_sig,
  input  logic          rst,
  barker_sync_if.slave  bus
);

  localparam int                CW     = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]     LAST   = CW'(FRAME_LEN - 1);
  localparam logic signed [4:0] POS_TH = 5'(THRESH);
`ifdef BARKER_POLARITY_EN
  localparam logic signed [4:0] NEG_TH = -POS_TH;
`endif

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [6:0]        win_q, win_d, win_nxt;
  logic [2:0]        fill_q, fill_d, fill_nxt;
  logic [2:0]        m_cnt;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        corr_q, corr_d, corr_nxt;
  logic signed [4:0] corr_ext;
  logic              sync_q, sync_d;
  logic              locked_q, locked_d;
  logic              data_q, data_d;
  logic              dvld_q, dvld_d;
  logic              fend_q, fend_d;
  logic              pol_q, pol_d;

  // Correlator on the window as it will be after this strobe.
  always_comb begin
    win_nxt = {win_q[5:0], bus.bit_in};
    m_cnt   = '0;
    for (int i = 0; i < 7; i++) begin
      m_cnt = m_cnt + {2'b00, ~(win_nxt[i] ^ BARKER_CODE[i])};
    end
    corr_nxt = {m_cnt, 1'b0} - 4'd7;
    corr_ext = {corr_nxt[3], corr_nxt};
    fill_nxt = (fill_q == 3'd7) ? 3'd7 : fill_q + 3'd1;
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    corr_d   = corr_q;
    locked_d = locked_q;
    data_d   = data_q;
    pol_d    = pol_q;
    sync_d   = 1'b0;
    dvld_d   = 1'b0;
    fend_d   = 1'b0;

    if (bus.en_p) begin
      win_d  = win_nxt;
      corr_d = corr_nxt;
      fill_d = fill_nxt;
      case (state_q)
        SEARCH: begin
          if (fill_nxt == 3'd7 && corr_ext >= POS_TH) begin
            sync_d   = 1'b1;
            locked_d = 1'b1;
            cnt_d    = '0;
            pol_d    = 1'b0;
            state_d  = LOCKED;
          end
`ifdef BARKER_POLARITY_EN
          else if (fill_nxt == 3'd7 && corr_ext <= NEG_TH) begin
            sync_d   = 1'b1;
            locked_d = 1'b1;
            cnt_d    = '0;
            pol_d    = 1'b1;
            state_d  = LOCKED;
          end
`endif
        end
        LOCKED: begin
          data_d = bus.bit_in ^ pol_q;
          dvld_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          // Clearing fill forces a full 7-bit refill before the next sync.
          if (cnt_q == LAST) begin
            fend_d   = 1'b1;
            locked_d = 1'b0;
            fill_d   = '0;
            cnt_d    = '0;
            state_d  = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_sig or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      win_q    <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      corr_q   <= '0;
      sync_q   <= 1'b0;
      locked_q <= 1'b0;
      data_q   <= 1'b0;
      dvld_q   <= 1'b0;
      fend_q   <= 1'b0;
      pol_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      corr_q   <= corr_d;
      sync_q   <= sync_d;
      locked_q <= locked_d;
      data_q   <= data_d;
      dvld_q   <= dvld_d;
      fend_q   <= fend_d;
      pol_q    <= pol_d;
    end
  end

  assign bus.corr        = corr_q;
  assign bus.sync_p      = sync_q;
  assign bus.locked      = locked_q;
  assign bus.data_out    = data_q;
  assign bus.data_valid  = dvld_q;
  assign bus.frame_end_p = fend_q;
  assign bus.polarity    = pol_q;

endmodule

// File: tb/tb_barker_sync.sv
// Scoreboard bench for barker_sync: stimulus pushes expected sync/payload events,
// monitors pop them whenever sync_p or data_valid is seen.
module tb_barker_sync;

  logic clk_sig = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_sig = ~clk_sig;

  barker_sync_if i7 ();
  barker_sync_if i5 ();

  barker_sync #(.THRESH(7)) u7 (.clk_sig(clk_sig), .rst(rst), .bus(i7.slave));
  barker_sync #(.THRESH(5)) u5 (.clk_sig(clk_sig), .rst(rst), .bus(i5.slave));

  typedef struct packed {
    logic       is_sync;
    logic [3:0] corr;
    logic       pol;
    logic       dat;
    logic       fe;
  } exp_t;

  exp_t q7[$];
  exp_t q5[$];
  exp_t e7, e5;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor for the THRESH=7 instance.
  always @(posedge clk_sig) begin
    #1;
    if (!rst && (i7.sync_p || i7.data_valid)) begin
      if (q7.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL u7_unexpected: got sync_p=%0b data_valid=%0b expected no output", i7.sync_p, i7.data_valid);
      end else begin
        e7 = q7.pop_front();
        if (e7.is_sync) begin
          chk("u7_sync_p",   32'(i7.sync_p),   32'd1);
          chk("u7_corr",     32'(i7.corr),     32'(e7.corr));
          chk("u7_polarity", 32'(i7.polarity), 32'(e7.pol));
          chk("u7_locked",   32'(i7.locked),   32'd1);
        end else begin
          chk("u7_data_valid",  32'(i7.data_valid),  32'd1);
          chk("u7_data_out",    32'(i7.data_out),    32'(e7.dat));
          chk("u7_frame_end_p", 32'(i7.frame_end_p), 32'(e7.fe));
        end
      end
    end
  end

  // Monitor for the THRESH=5 instance.
  always @(posedge clk_sig) begin
    #1;
    if (!rst && (i5.sync_p || i5.data_valid)) begin
      if (q5.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL u5_unexpected: got sync_p=%0b data_valid=%0b expected no output", i5.sync_p, i5.data_valid);
      end else begin
        e5 = q5.pop_front();
        chk("u5_sync_p", 32'(i5.sync_p), 32'(e5.is_sync));
        chk("u5_corr",   32'(i5.corr),   32'(e5.corr));
        chk("u5_locked", 32'(i5.locked), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Called at a negedge; returns at a negedge after the strobe has been registered.
  task automatic send_bit(input logic b, input bit to5, input int gap);
    i7.en_p   = 1'b1;
    i7.bit_in = b;
    if (to5) begin
      i5.en_p   = 1'b1;
      i5.bit_in = b;
    end
    @(negedge clk_sig);
    i7.en_p = 1'b0;
    i5.en_p = 1'b0;
    repeat (gap) @(negedge clk_sig);
  endtask

  task automatic send_code(input logic [6:0] c, input bit to5, input bit rnd);
    for (int i = 6; i >= 0; i--)
      send_bit(c[i], to5, rnd ? int'($urandom_range(0, 5)) : 0);
  endtask

  task automatic push_sync(input logic [3:0] c, input logic p);
    q7.push_back('{is_sync: 1'b1, corr: c, pol: p, dat: 1'b0, fe: 1'b0});
  endtask

  task automatic send_payload(input logic [31:0] w, input logic pol, input int nbits, input bit rnd);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = w[31-i];
      q7.push_back('{is_sync: 1'b0, corr: 4'h0, pol: 1'b0, dat: b ^ pol, fe: (i == 31)});
      send_bit(b, 1'b0, rnd ? int'($urandom_range(0, 5)) : 0);
    end
  endtask

  initial begin
    i7.en_p = 1'b0; i7.bit_in = 1'b0;
    i5.en_p = 1'b0; i5.bit_in = 1'b0;
    repeat (3) @(negedge clk_sig);
    chk("reset_u7_outputs", 32'({i7.corr, i7.sync_p, i7.locked, i7.data_out,
                                 i7.data_valid, i7.frame_end_p, i7.polarity}), 32'd0);
    chk("reset_u5_outputs", 32'({i5.corr, i5.sync_p, i5.locked, i5.data_valid}), 32'd0);
    rst = 1'b0;
    @(negedge clk_sig);

    // Plain sync on the code.
    push_sync(4'h7, 1'b0);
    send_code(7'b1110010, 1'b0, 1'b0);
    chk("t1_locked", 32'(i7.locked), 32'd1);
    chk("t1_corr",   32'(i7.corr),   32'h7);

    // Full frame; locked drops with the last bit.
    send_payload(32'hA5A50F0F, 1'b0, 32, 1'b0);
    chk("t2_locked_after_end", 32'(i7.locked), 32'd0);

    // One-bit error: corr +5 syncs THRESH=5 only.
    q5.push_back('{is_sync: 1'b1, corr: 4'h5, pol: 1'b0, dat: 1'b0, fe: 1'b0});
    send_code(7'b1111010, 1'b1, 1'b0);
    chk("t3_u7_corr",   32'(i7.corr),   32'h5);
    chk("t3_u7_locked", 32'(i7.locked), 32'd0);

    // Inverted code: corr -7.
`ifdef BARKER_POLARITY_EN
    push_sync(4'h9, 1'b1);
`endif
    send_code(7'b0001101, 1'b0, 1'b0);
    chk("t4_corr", 32'(i7.corr), 32'h9);
`ifdef BARKER_POLARITY_EN
    send_payload(32'hA5A50F0F, 1'b1, 32, 1'b0);
    chk("t4_polarity_hold", 32'(i7.polarity), 32'd1);
`else
    chk("t4_no_lock", 32'(i7.locked), 32'd0);
`endif

    // Reset during payload bit 10, then partial refill must not sync.
    push_sync(4'h7, 1'b0);
    send_code(7'b1110010, 1'b0, 1'b0);
    send_payload(32'hA5A50F0F, 1'b0, 10, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_reset_outputs", 32'({i7.corr, i7.sync_p, i7.locked, i7.data_out,
                                  i7.data_valid, i7.frame_end_p, i7.polarity}), 32'd0);
    @(negedge clk_sig);
    rst = 1'b0;
    @(negedge clk_sig);
    for (int i = 5; i >= 0; i--) send_bit(1'(7'b1110010 >> i), 1'b0, 0);
    chk("t5_six_bits_no_lock", 32'(i7.locked), 32'd0);
    push_sync(4'h7, 1'b0);
    send_code(7'b1110010, 1'b0, 1'b0);
    send_payload(32'hA5A50F0F, 1'b0, 32, 1'b0);

    // Random strobe gaps; payload tail holds the code and must not retrigger.
    push_sync(4'h7, 1'b0);
    send_code(7'b1110010, 1'b0, 1'b1);
    send_payload(32'hA5A50F72, 1'b0, 32, 1'b1);
    chk("t6_tail_unlocked", 32'(i7.locked), 32'd0);
    push_sync(4'h7, 1'b0);
    send_code(7'b1110010, 1'b0, 1'b0);
    send_payload(32'hA5A50F0F, 1'b0, 32, 1'b1);

    repeat (5) @(negedge clk_sig);
    chk("u7_queue_drained", 32'(q7.size()), 32'd0);
    chk("u5_queue_drained", 32'(q5.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
